// File: rtl/uncached_store_buffer.sv
// uncached_store_buffer: posted in-order buffer for uncached stores, drained as single-beat AXI3 writes.
// Define UNCACHED_STORE_MERGE_EN to merge full-word stores into the not-yet-issued tail entry.
module uncached_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter logic [3:0]  AXI_ID = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_strb,
    input  logic [2:0]  st_size,
    input  logic [31:0] chk_addr,
    output logic        chk_hit,
    output logic        empty,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

    state_t      state_q;
    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [3:0]  strb_q [DEPTH];
    logic [2:0]  size_q [DEPTH];
    logic [AW-1:0] head_q, tail_q, last;
    logic [AW:0]   count_q;
    logic        awvalid_q, wvalid_q, bready_q;
    logic [31:0] awaddr_q, wdata_q;
    logic [2:0]  awsize_q;
    logic [3:0]  wstrb_q;
    logic        push, pop, merge_ok, merge;
    logic        unused;

    assign last = tail_q - 1'b1;
    assign pop  = state_q == RESP && bvalid;
`ifdef UNCACHED_STORE_MERGE_EN
    // count > 1 guarantees the tail is not the head the drain FSM has loaded
    assign merge_ok = |count_q[AW:1] && st_size == 3'd2 && addr_q[last][31:2] == st_addr[31:2];
`else
    assign merge_ok = 1'b0;
`endif
    assign merge    = st_valid && merge_ok;
    assign st_ready = count_q != FULL || merge_ok;
    assign push     = st_valid && st_ready && !merge;
    assign empty    = count_q == '0 && state_q == IDLE;

    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign awlen   = 4'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wlast   = 1'b1;
    assign awvalid = awvalid_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;
    assign awaddr  = awaddr_q;
    assign awsize  = awsize_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign unused  = ^{bid, bresp, chk_addr[1:0]};

    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, AW'(i) - head_q} < count_q && addr_q[i][31:2] == chk_addr[31:2])
                chk_hit = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
            strb_q[tail_q] <= st_strb;
            size_q[tail_q] <= st_size;
        end else if (merge) begin
            for (int b = 0; b < 4; b++)
                if (st_strb[b]) data_q[last][8*b +: 8] <= st_data[8*b +: 8];
            strb_q[last] <= strb_q[last] | st_strb;
            size_q[last] <= 3'd2;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop) head_q <= head_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            awsize_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (count_q != '0) begin
                    awaddr_q  <= addr_q[head_q];
                    awsize_q  <= size_q[head_q];
                    wdata_q   <= data_q[head_q];
                    wstrb_q   <= strb_q[head_q];
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    state_q   <= SEND;
                end
                SEND: begin
                    awvalid_q <= awvalid_q && !awready;
                    wvalid_q  <= wvalid_q && !wready;
                    if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: if (bvalid) begin
                    bready_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
